// File: rtl/dma_xfer_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : dma_xfer_sequencer                                            |
// | Description : Splits a host DMA job into chunks and drives the MWr/MRd      |
// |               engine start/done handshakes with abort and timeout handling. |
// | Revision    : 1.0                                                           |
// +-----------------------------------------------------------------------------+
module dma_xfer_sequencer #(
    parameter int unsigned CHUNK_DW    = 1024,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        job_valid_i,
    output logic        job_ready_o,
    input  logic        job_dir_i,
    input  logic [31:0] job_addr_i,
    input  logic [31:0] job_dw_count_i,
    input  logic [2:0]  cfg_prg_max_payload_size,
    input  logic [2:0]  cfg_max_rd_req_size,
    input  logic        abort_i,
    output logic        mwr_start_o,
    output logic [31:0] mwr_addr_o,
    output logic [15:0] mwr_len_o,
    output logic [31:0] mwr_size_o,
    input  logic        mwr_done_i,
    output logic        mwr_done_clr,
    output logic        mrd_start_o,
    output logic [31:0] mrd_addr_o,
    output logic [15:0] mrd_len_o,
    output logic [31:0] mrd_size_o,
    input  logic        mrd_done_i,
    output logic        mrd_done_clr,
    output logic        job_done_o,
    output logic        job_err_o,
    output logic        irq_o,
    input  logic        irq_clr_i,
    output logic [15:0] chunks_done_o
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LOAD  = 3'd1;
    localparam logic [2:0] c_ST_START = 3'd2;
    localparam logic [2:0] c_ST_WAIT  = 3'd3;
    localparam logic [2:0] c_ST_CLR   = 3'd4;
    localparam logic [2:0] c_ST_NEXT  = 3'd5;
    localparam logic [2:0] c_ST_DONE  = 3'd6;

    localparam logic [31:0] c_CHUNK   = 32'(CHUNK_DW);
    localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT_CYC);

    logic [2:0]  r_state;
    logic        r_dir;
    logic [31:0] r_addr;
    logic [31:0] r_rem;
    logic [31:0] r_chunk;
    logic [15:0] r_len;
    logic [15:0] r_cnt;
    logic        r_err;
    logic        r_start;
    logic        r_done_clr;
    logic [31:0] r_eng_addr;
    logic [15:0] r_eng_len;
    logic [31:0] r_eng_size;
    logic        r_job_done;
    logic        r_job_err;
    logic        r_irq;
    logic [15:0] r_chunks;

    logic        w_done;
    logic        w_abort;
    logic [2:0]  w_enc_raw;
    logic [2:0]  w_enc;
    logic [15:0] w_tlp;
    logic [31:0] w_chunk;
    logic [15:0] w_len;

    assign w_done    = r_dir ? mrd_done_i : mwr_done_i;
    assign w_abort   = abort_i && (r_state != c_ST_IDLE) && (r_state != c_ST_DONE);
    assign w_enc_raw = r_dir ? cfg_max_rd_req_size : cfg_prg_max_payload_size;
    assign w_enc     = (w_enc_raw > 3'd5) ? 3'd5 : w_enc_raw;
    assign w_tlp     = 16'd32 << w_enc;
    assign w_chunk   = (r_rem > c_CHUNK) ? c_CHUNK : r_rem;
    assign w_len     = (w_chunk > {16'd0, w_tlp}) ? w_tlp : w_chunk[15:0];

    // Outputs are registered by the action of the state being left, so start
    // appears on the edge that exits START and done_clr on the edge exiting CLR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_dir      <= 1'b0;
            r_addr     <= '0;
            r_rem      <= '0;
            r_chunk    <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_start    <= 1'b0;
            r_done_clr <= 1'b0;
            r_eng_addr <= '0;
            r_eng_len  <= '0;
            r_eng_size <= '0;
            r_job_done <= 1'b0;
            r_job_err  <= 1'b0;
            r_irq      <= 1'b0;
            r_chunks   <= '0;
        end else begin
            r_job_done <= 1'b0;
            r_job_err  <= 1'b0;
            if (irq_clr_i) begin
                r_irq <= 1'b0;
            end
            if (w_abort) begin
                // In NEXT the CLR pulse is already on the wire; do not stretch it.
                r_state    <= c_ST_DONE;
                r_err      <= 1'b1;
                r_start    <= 1'b0;
                r_done_clr <= (r_state != c_ST_NEXT);
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (job_valid_i) begin
                            r_dir    <= job_dir_i;
                            r_addr   <= job_addr_i;
                            r_rem    <= job_dw_count_i;
                            r_chunks <= '0;
                            r_err    <= 1'b0;
                            r_state  <= (job_dw_count_i != 32'd0) ? c_ST_LOAD : c_ST_DONE;
                        end
                    end
                    c_ST_LOAD: begin
                        r_chunk <= w_chunk;
                        r_len   <= w_len;
                        r_state <= c_ST_START;
                    end
                    c_ST_START: begin
                        r_eng_addr <= r_addr;
                        r_eng_len  <= r_len;
                        r_eng_size <= r_chunk;
                        r_start    <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= c_ST_WAIT;
                    end
                    c_ST_WAIT: begin
                        if (w_done) begin
                            r_state <= c_ST_CLR;
                        end else if (r_cnt == c_TIMEOUT) begin
                            r_state <= c_ST_DONE;
                            r_err   <= 1'b1;
                            r_start <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    c_ST_CLR: begin
                        r_start    <= 1'b0;
                        r_done_clr <= 1'b1;
                        r_state    <= c_ST_NEXT;
                    end
                    c_ST_NEXT: begin
                        r_done_clr <= 1'b0;
                        r_addr     <= r_addr + {r_chunk[29:0], 2'b00};
                        r_rem      <= r_rem - r_chunk;
                        r_chunks   <= r_chunks + 16'd1;
                        r_state    <= (r_rem == r_chunk) ? c_ST_DONE : c_ST_LOAD;
                    end
                    c_ST_DONE: begin
                        r_done_clr <= 1'b0;
                        r_start    <= 1'b0;
                        r_eng_addr <= '0;
                        r_eng_len  <= '0;
                        r_eng_size <= '0;
                        r_job_done <= 1'b1;
                        r_job_err  <= r_err;
                        r_irq      <= 1'b1;
                        r_state    <= c_ST_IDLE;
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Engine registers are cleared in DONE, so retargeting by dir at the next
    // handshake never exposes stale values on the other engine.
    assign job_ready_o   = (r_state == c_ST_IDLE);
    assign mwr_start_o   = r_start & ~r_dir;
    assign mwr_done_clr  = r_done_clr & ~r_dir;
    assign mwr_addr_o    = r_dir ? 32'd0 : r_eng_addr;
    assign mwr_len_o     = r_dir ? 16'd0 : r_eng_len;
    assign mwr_size_o    = r_dir ? 32'd0 : r_eng_size;
    assign mrd_start_o   = r_start & r_dir;
    assign mrd_done_clr  = r_done_clr & r_dir;
    assign mrd_addr_o    = r_dir ? r_eng_addr : 32'd0;
    assign mrd_len_o     = r_dir ? r_eng_len : 16'd0;
    assign mrd_size_o    = r_dir ? r_eng_size : 32'd0;
    assign job_done_o    = r_job_done;
    assign job_err_o     = r_job_err;
    assign irq_o         = r_irq;
    assign chunks_done_o = r_chunks;

endmodule
`default_nettype wire

// File: tb/tb_dma_xfer_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// Randomized bench for dma_xfer_sequencer: a chunk-list reference model built
// from the job parameters, plus an engine responder driving done/abort.
module tb_dma_xfer_sequencer;

    localparam int unsigned c_CHUNK = 1024;
    localparam int unsigned c_TMO   = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic        job_dir = 1'b0;
    logic [31:0] job_addr = '0;
    logic [31:0] job_cnt = '0;
    logic [2:0]  cfg_pl = '0;
    logic [2:0]  cfg_rd = '0;
    logic        abort = 1'b0;
    logic        mwr_start, mwr_done_clr, mrd_start, mrd_done_clr;
    logic [31:0] mwr_addr, mwr_size, mrd_addr, mrd_size;
    logic [15:0] mwr_len, mrd_len;
    logic        mwr_done = 1'b0;
    logic        mrd_done = 1'b0;
    logic        job_done, job_err, irq;
    logic        irq_clr = 1'b0;
    logic [15:0] chunks_done;

    always #5 clk = ~clk;

    dma_xfer_sequencer #(.CHUNK_DW(c_CHUNK), .TIMEOUT_CYC(c_TMO)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid_i(job_valid), .job_ready_o(job_ready), .job_dir_i(job_dir),
        .job_addr_i(job_addr), .job_dw_count_i(job_cnt),
        .cfg_prg_max_payload_size(cfg_pl), .cfg_max_rd_req_size(cfg_rd),
        .abort_i(abort),
        .mwr_start_o(mwr_start), .mwr_addr_o(mwr_addr), .mwr_len_o(mwr_len),
        .mwr_size_o(mwr_size), .mwr_done_i(mwr_done), .mwr_done_clr(mwr_done_clr),
        .mrd_start_o(mrd_start), .mrd_addr_o(mrd_addr), .mrd_len_o(mrd_len),
        .mrd_size_o(mrd_size), .mrd_done_i(mrd_done), .mrd_done_clr(mrd_done_clr),
        .job_done_o(job_done), .job_err_o(job_err), .irq_o(irq),
        .irq_clr_i(irq_clr), .chunks_done_o(chunks_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] e_addr[$];
    logic [31:0] e_len[$];
    logic [31:0] e_size[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected chunk list: greedy CHUNK_DW slices, each capped at one TLP for len.
    task automatic build_model(input logic dir, input logic [31:0] addr, input int unsigned cnt,
                               input logic [2:0] pl, input logic [2:0] rd);
        int unsigned rem, enc, tlp, c;
        logic [31:0] a;
        e_addr.delete();
        e_len.delete();
        e_size.delete();
        rem = cnt;
        a   = addr;
        enc = dir ? {29'd0, rd} : {29'd0, pl};
        if (enc > 5) enc = 5;
        tlp = 32 * (1 << enc);
        while (rem > 0) begin
            c = (rem < c_CHUNK) ? rem : c_CHUNK;
            e_size.push_back(c);
            e_len.push_back((c < tlp) ? c : tlp);
            e_addr.push_back(a);
            a   = a + 4 * c;
            rem = rem - c;
        end
    endtask

    // mode: 0 = normal, 1 = done withheld (timeout), 2 = abort+done at chunk abort_at
    task automatic run_job(input logic dir, input logic [31:0] addr, input int unsigned cnt,
                           input logic [2:0] pl, input logic [2:0] rd, input int mode,
                           input int abort_at, input logic irq_race);
        logic [31:0] o_addr[$];
        logic [31:0] o_len[$];
        logic [31:0] o_size[$];
        int n, first_start, clr_pulses, clr_high, start_hi, done_n, last_clr_n;
        int gap_bad, other_bad, ready_bad, low_run, hi_cnt, dly, exp_starts, exp_clr, exp_chunks;
        logic prev_start, prev_clr, pending, seen_done, done_err;
        logic s_start, s_clr, o_any;
        logic [31:0] s_addr, s_size;
        logic [15:0] s_len;

        build_model(dir, addr, cnt, pl, rd);
        first_start = -1; clr_pulses = 0; clr_high = 0; start_hi = 0; done_n = -1;
        last_clr_n = -1; gap_bad = 0; other_bad = 0; ready_bad = 0; low_run = 0; hi_cnt = 0;
        prev_start = 0; prev_clr = 0; pending = 0; seen_done = 0; done_err = 0;
        dly = $urandom_range(1, 4);

        @(negedge clk);
        check_eq("ready_before_job", 32'(job_ready), 32'd1);
        job_valid = 1'b1; job_dir = dir; job_addr = addr; job_cnt = cnt;
        cfg_pl = pl; cfg_rd = rd;
        @(posedge clk);
        n = 0;
        for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
            @(negedge clk);
            n++;
            job_valid = 1'b0;
            abort     = 1'b0;
            irq_clr   = 1'b0;
            s_start = dir ? mrd_start : mwr_start;
            s_clr   = dir ? mrd_done_clr : mwr_done_clr;
            s_addr  = dir ? mrd_addr : mwr_addr;
            s_len   = dir ? mrd_len : mwr_len;
            s_size  = dir ? mrd_size : mwr_size;
            o_any   = dir ? (mwr_start | mwr_done_clr | (|mwr_addr) | (|mwr_len) | (|mwr_size))
                          : (mrd_start | mrd_done_clr | (|mrd_addr) | (|mrd_len) | (|mrd_size));
            if (o_any) other_bad++;
            if (job_done) begin
                seen_done = 1'b1;
                done_n    = n;
                done_err  = job_err;
            end else if (job_ready) begin
                ready_bad++;
            end
            if (s_start && !prev_start) begin
                if (first_start < 0) first_start = n;
                else if (low_run != 3) gap_bad++;
                o_addr.push_back(s_addr);
                o_len.push_back({16'd0, s_len});
                o_size.push_back(s_size);
                hi_cnt = 0;
            end
            if (s_start) begin
                low_run = 0;
                start_hi++;
            end else begin
                low_run++;
            end
            if (s_clr) clr_high++;
            if (s_clr && !prev_clr) begin
                clr_pulses++;
                last_clr_n = n;
            end
            if (s_clr) begin
                mwr_done = 1'b0;
                mrd_done = 1'b0;
                pending  = 1'b0;
            end
            if (s_start && !pending && mode != 1) begin
                hi_cnt++;
                if (hi_cnt == dly) begin
                    if (dir) mrd_done = 1'b1; else mwr_done = 1'b1;
                    pending = 1'b1;
                    if (mode == 2 && o_addr.size() == abort_at + 1) abort = 1'b1;
                    dly = $urandom_range(1, 4);
                end
            end
            if (irq_race && o_addr.size() == e_addr.size() && last_clr_n > 0 && n == last_clr_n + 1)
                irq_clr = 1'b1;
            prev_start = s_start;
            prev_clr   = s_clr;
        end
        mwr_done = 1'b0;
        mrd_done = 1'b0;

        check_eq("job_done_seen", 32'(seen_done), 32'd1);
        @(negedge clk);
        check_eq("job_done_width", 32'(job_done), 32'd0);

        exp_starts = (mode == 0) ? e_addr.size() : (mode == 1) ? 1 : abort_at + 1;
        exp_clr    = (mode == 0) ? e_addr.size() : (mode == 1) ? 0 : abort_at + 1;
        exp_chunks = (mode == 0) ? e_addr.size() : (mode == 1) ? 0 : abort_at;
        check_eq("start_count", 32'(o_addr.size()), 32'(exp_starts));
        for (int i = 0; i < o_addr.size() && i < exp_starts; i++) begin
            check_eq($sformatf("chunk%0d_addr", i), o_addr[i], e_addr[i]);
            check_eq($sformatf("chunk%0d_len", i), o_len[i], e_len[i]);
            check_eq($sformatf("chunk%0d_size", i), o_size[i], e_size[i]);
        end
        check_eq("done_clr_pulses", 32'(clr_pulses), 32'(exp_clr));
        check_eq("done_clr_width", 32'(clr_high), 32'(clr_pulses));
        check_eq("job_err", 32'(done_err), (mode == 0) ? 32'd0 : 32'd1);
        check_eq("chunks_done", {16'd0, chunks_done}, 32'(exp_chunks));
        check_eq("other_engine_quiet", 32'(other_bad), 32'd0);
        check_eq("ready_low_in_job", 32'(ready_bad), 32'd0);
        check_eq("inter_chunk_gap", 32'(gap_bad), 32'd0);
        check_eq("start_low_after", 32'(mwr_start | mrd_start), 32'd0);
        if (cnt > 0) check_eq("start_latency", 32'(first_start), 32'd3);
        else         check_eq("zero_cnt_done_cycle", 32'(done_n), 32'd2);
        // counter runs 0..TIMEOUT_CYC inclusive while start is held
        if (mode == 1) check_eq("timeout_start_cycles", 32'(start_hi), 32'(c_TMO + 1));
        check_eq(irq_race ? "irq_race_kept" : "irq_set", 32'(irq), 32'd1);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        check_eq("irq_cleared", 32'(irq), 32'd0);
    endtask

    task automatic reset_mid_job();
        int guard, bad;
        @(negedge clk);
        job_valid = 1'b1; job_dir = 1'b0; job_addr = 32'h2000_0000; job_cnt = 32'd3000;
        @(negedge clk);
        job_valid = 1'b0;
        guard = 0;
        while (!mwr_start && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_eq("rst_job_started", 32'(mwr_start), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_ready", 32'(job_ready), 32'd1);
        check_eq("rst_start", 32'(mwr_start), 32'd0);
        check_eq("rst_addr", mwr_addr, 32'd0);
        check_eq("rst_size", mwr_size, 32'd0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (job_done || mwr_done_clr || mrd_done_clr) bad++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (job_done || mwr_done_clr || mrd_done_clr || mwr_start) bad++;
        end
        check_eq("rst_no_pulses", 32'(bad), 32'd0);
    endtask

    initial begin
        logic [31:0] r_addr;
        int unsigned r_cnt;
        int mode, at;
        logic dir;
        logic [2:0] pl, rd;

        repeat (2) @(negedge clk);
        check_eq("reset_ready", 32'(job_ready), 32'd1);
        check_eq("reset_done", 32'(job_done | job_err), 32'd0);
        check_eq("reset_irq", 32'(irq), 32'd0);
        check_eq("reset_starts", 32'(mwr_start | mrd_start | mwr_done_clr | mrd_done_clr), 32'd0);
        check_eq("reset_chunks", {16'd0, chunks_done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_job(1'b0, 32'h1000_0000, 2500, 3'd1, 3'd0, 0, 0, 1'b0);
        run_job(1'b1, 32'h0400_0040, 16, 3'd0, 3'd7, 0, 0, 1'b0);
        run_job(1'b0, 32'h0000_0100, 0, 3'd2, 3'd2, 0, 0, 1'b0);
        run_job(1'b0, 32'h3000_0000, 200, 3'd2, 3'd0, 1, 0, 1'b0);
        run_job(1'b1, 32'h5000_0000, 3000, 3'd0, 3'd2, 2, 1, 1'b0);
        run_job(1'b0, 32'hFFFF_F000, 2048, 3'd3, 3'd0, 0, 0, 1'b1);

        for (int j = 0; j < 8; j++) begin
            r_addr = $urandom;
            r_addr = r_addr & 32'hFFFF_FFFC;
            r_cnt  = $urandom_range(0, 4500);
            dir    = 1'($urandom_range(0, 1));
            pl     = 3'($urandom_range(0, 7));
            rd     = 3'($urandom_range(0, 7));
            mode   = 0;
            at     = 0;
            if (r_cnt > c_CHUNK && $urandom_range(0, 2) == 0) begin
                mode = 2;
                at   = $urandom_range(0, (r_cnt - 1) / c_CHUNK);
            end
            run_job(dir, r_addr, r_cnt, pl, rd, mode, at, 1'b0);
        end

        reset_mid_job();
        run_job(1'b1, 32'h0000_8000, 1100, 3'd0, 3'd4, 0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
